// File: rtl/alu_drv_pkg.sv
// Shared types, widths and the golden ALU model for the ALU command driver.
package alu_drv_pkg;

  localparam int unsigned OPC_W  = 2;
  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = OPND_W + 1;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NOT = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drv_state_e;

  // One queued command without its tag; the tag width is a module parameter.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } alu_cmd_t;

  // Expected ALU result for one command. An opcode that is not one of the
  // four defined encodings (including X in simulation) falls to zero.
  function automatic logic signed [RES_W-1:0] alu_golden(
    input logic [OPC_W-1:0]  op,
    input logic [OPND_W-1:0] a,
    input logic [OPND_W-1:0] b
  );
    logic signed [RES_W-1:0] ax;
    logic signed [RES_W-1:0] bx;
    logic signed [RES_W-1:0] res;
    ax = {a[OPND_W-1], a};
    bx = {b[OPND_W-1], b};
    case (op)
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_NOT:  res = ~ax;
      OP_OR:   res = {{(RES_W-1){1'b0}}, |b};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry one extra
// wrap bit so full and empty are distinguishable with DEPTH a power of two.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; both may move in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the registered 4-bit ALU: queues tagged commands, issues one
// at a time, captures the result after LAT clocks, checks it against the
// golden model and returns it on a valid/ready response port.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OPC_W-1:0]         cmd_opcode,
  input  logic signed [OPND_W-1:0] cmd_a,
  input  logic signed [OPND_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [OPC_W-1:0]         alu_opcode,
  output logic signed [OPND_W-1:0] alu_a,
  output logic signed [OPND_W-1:0] alu_b,
  input  logic signed [RES_W-1:0]  alu_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic signed [RES_W-1:0]  rsp_c,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_mismatch,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         done_count
);

  localparam int unsigned CMD_W  = $bits(alu_cmd_t);
  localparam int unsigned FIFO_W = CMD_W + TAG_W;
  localparam int unsigned LAT_W  = $clog2(LAT + 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  alu_cmd_t          in_cmd;
  alu_cmd_t          head_cmd;
  logic [TAG_W-1:0]  head_tag;

  drv_state_e              state_q, state_d;
  logic [LAT_W-1:0]        cnt_q, cnt_d;
  logic [OPC_W-1:0]        alu_op_q, alu_op_d;
  logic [OPND_W-1:0]       alu_a_q, alu_a_d;
  logic [OPND_W-1:0]       alu_b_q, alu_b_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic signed [RES_W-1:0] golden_q, golden_d;
  logic signed [RES_W-1:0] rsp_c_q, rsp_c_d;
  logic                    rsp_mm_q, rsp_mm_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic [CNT_W-1:0]        done_q, done_d;

  assign in_cmd.opcode = cmd_opcode;
  assign in_cmd.a      = cmd_a;
  assign in_cmd.b      = cmd_b;
  assign fifo_wdata    = {in_cmd, cmd_tag};
  assign {head_cmd, head_tag} = fifo_rdata;

  // No bypass: readiness depends only on the registered fill level.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue/wait/respond sequencing and the response counters.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    tag_d       = tag_q;
    golden_d    = golden_q;
    rsp_c_d     = rsp_c_q;
    rsp_mm_d    = rsp_mm_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    done_d      = done_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_op_d = head_cmd.opcode;
          alu_a_d  = head_cmd.a;
          alu_b_d  = head_cmd.b;
          tag_d    = head_tag;
          golden_d = alu_golden(head_cmd.opcode, head_cmd.a, head_cmd.b);
          cnt_d    = LAT_W'(LAT);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          rsp_c_d     = alu_c;
          rsp_mm_d    = (alu_c != golden_q);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_d      = done_q + CNT_W'(1);
          if (rsp_mm_q && (err_q != '1)) err_d = err_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      tag_q       <= '0;
      golden_q    <= '0;
      rsp_c_q     <= '0;
      rsp_mm_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      tag_q       <= tag_d;
      golden_q    <= golden_d;
      rsp_c_q     <= rsp_c_d;
      rsp_mm_q    <= rsp_mm_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign alu_opcode   = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_c        = rsp_c_q;
  assign rsp_tag      = tag_q;
  assign rsp_mismatch = rsp_mm_q;
  assign err_count    = err_q;
  assign done_count   = done_q;

endmodule
